// File: rtl/des_block_serializer_if.sv
// Block-in / byte-out bus of the DES block serializer.
// master: serializer side (captures blocks, drives the byte stream); slave: upstream core plus byte sink.
interface des_block_serializer_if;
   logic [63:0] trans_data;
   logic        trans_data_ready;
   logic        handshake_ack;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx_last;

   modport master (
      input  trans_data, trans_data_ready, tx_ready,
      output handshake_ack, tx_byte, tx_valid, tx_last
   );

   modport slave (
      output trans_data, trans_data_ready, tx_ready,
      input  handshake_ack, tx_byte, tx_valid, tx_last
   );
endinterface

// File: rtl/des_block_serializer.sv
// Captures 64-bit DES blocks and streams them out as 8 bytes on a valid/ready link.
// Optional macro DES_SER_DOUBLE_BUF_EN adds a hold register so blocks stream with no IDLE bubble.
module des_block_serializer #(
   parameter int LSB_FIRST = 0,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   des_block_serializer_if.master bus,
   output logic                 busy,
   output logic [CNT_W-1:0]     blocks_sent
);
   typedef enum logic {IDLE, SEND} state_t;

   state_t      state;
   logic [63:0] sreg;
   logic [2:0]  idx;
   logic        armed;
   logic        ack_q;
   logic        accept;
   logic        cap;
   logic [63:0] sreg_shift;
   logic [7:0]  cur_byte;

   assign accept = (state == SEND) && bus.tx_ready;

   // The shift register always presents the next byte at the same end.
   assign cur_byte   = (LSB_FIRST != 0) ? sreg[7:0] : sreg[63:56];
   assign sreg_shift = (LSB_FIRST != 0) ? (sreg >> 8) : (sreg << 8);

`ifdef DES_SER_DOUBLE_BUF_EN
   logic [63:0] hold;
   logic        hold_full;

   assign cap  = armed && bus.trans_data_ready && ((state == IDLE) || !hold_full);
   assign busy = (state == SEND) || hold_full;
`else
   assign cap  = armed && bus.trans_data_ready && (state == IDLE);
   assign busy = (state == SEND);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sreg        <= '0;
         idx         <= '0;
         armed       <= 1'b0;
         ack_q       <= 1'b0;
         blocks_sent <= '0;
`ifdef DES_SER_DOUBLE_BUF_EN
         hold        <= '0;
         hold_full   <= 1'b0;
`endif
      end else begin
         ack_q <= cap;
         // Upstream ready stays high a cycle past the ack; require a low sample before recapturing.
         if (cap)
            armed <= 1'b0;
         else if (!bus.trans_data_ready)
            armed <= 1'b1;

         case (state)
            IDLE: begin
               if (cap) begin
                  sreg  <= bus.trans_data;
                  idx   <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               if (accept) begin
                  if (idx == 3'd7) begin
                     blocks_sent <= blocks_sent + CNT_W'(1);
                     idx         <= '0;
`ifdef DES_SER_DOUBLE_BUF_EN
                     if (hold_full) begin
                        sreg      <= hold;
                        hold_full <= 1'b0;
                     end else if (cap) begin
                        sreg <= bus.trans_data;
                     end else begin
                        state <= IDLE;
                     end
`else
                     state <= IDLE;
`endif
                  end else begin
                     idx  <= idx + 3'd1;
                     sreg <= sreg_shift;
                  end
               end
            end
            default: state <= IDLE;
         endcase

`ifdef DES_SER_DOUBLE_BUF_EN
         // A capture coinciding with the last byte goes straight to sreg above.
         if ((state == SEND) && cap && !(accept && (idx == 3'd7))) begin
            hold      <= bus.trans_data;
            hold_full <= 1'b1;
         end
`endif
      end
   end

   assign bus.handshake_ack = ack_q;
   assign bus.tx_valid      = (state == SEND);
   assign bus.tx_last       = (state == SEND) && (idx == 3'd7);
   assign bus.tx_byte       = (state == SEND) ? cur_byte : 8'h00;
endmodule

// File: tb/tb_des_block_serializer.sv
// Self-checking bench: three serializer instances (MSB-first, LSB-first, 3-bit counter) on shared stimulus.
module tb_des_block_serializer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] td  = '0;
   logic        tdr = 1'b0;
   logic        txr = 1'b1;

   logic        busy_m, busy_l, busy_w;
   logic [15:0] cnt_m, cnt_l;
   logic [2:0]  cnt_w;

   des_block_serializer_if bm();
   des_block_serializer_if bl();
   des_block_serializer_if bw();

   assign bm.trans_data = td;  assign bm.trans_data_ready = tdr;  assign bm.tx_ready = txr;
   assign bl.trans_data = td;  assign bl.trans_data_ready = tdr;  assign bl.tx_ready = txr;
   assign bw.trans_data = td;  assign bw.trans_data_ready = tdr;  assign bw.tx_ready = txr;

   des_block_serializer u_dut (.clk(clk), .rst(rst), .bus(bm.master), .busy(busy_m), .blocks_sent(cnt_m));
   des_block_serializer #(.LSB_FIRST(1)) u_lsb (.clk(clk), .rst(rst), .bus(bl.master), .busy(busy_l), .blocks_sent(cnt_l));
   des_block_serializer #(.CNT_W(3)) u_wrap (.clk(clk), .rst(rst), .bus(bw.master), .busy(busy_w), .blocks_sent(cnt_w));

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int exp_blocks = 0;
   int ack_cnt, vld_cnt, first_vld, last_vld, last_ack;
   int cyc = 0;
   bit hold_high = 1'b0;
   logic [8:0] exp_m[$], exp_l[$], obs_m[$], obs_l[$];

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clear_sb();
      exp_m.delete(); exp_l.delete(); obs_m.delete(); obs_l.delete();
      ack_cnt = 0; vld_cnt = 0; first_vld = -1; last_vld = -1; last_ack = -1;
   endtask

   // Present a block and push the bytes each instance must emit, {last, byte}.
   task automatic present_block(input logic [63:0] d);
      td = d; tdr = 1'b1; exp_blocks++;
      for (int i = 0; i < 8; i++) begin
         exp_m.push_back({(i == 7), d[63-8*i -: 8]});
         exp_l.push_back({(i == 7), d[8*i +: 8]});
      end
   endtask

   // Record the current cycle (accepted bytes, acks) then advance; releases ready after an ack.
   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         if (bm.tx_valid && txr) obs_m.push_back({bm.tx_last, bm.tx_byte});
         if (bl.tx_valid && txr) obs_l.push_back({bl.tx_last, bl.tx_byte});
         if (bm.tx_valid) begin
            vld_cnt++;
            if (first_vld < 0) first_vld = cyc;
            last_vld = cyc;
         end
         if (bm.handshake_ack) begin
            ack_cnt++; last_ack = cyc;
            if (!hold_high) tdr = 1'b0;
         end
         cyc++;
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; tdr = 1'b0; txr = 1'b1; td = '0;
      tick(); tick();
      vectors++; if (bm.handshake_ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack: got %b want 0", bm.handshake_ack); end
      vectors++; if (bm.tx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", bm.tx_valid); end
      vectors++; if (bm.tx_last !== 1'b0) begin miscompares++; $display("FAIL rst_last: got %b want 0", bm.tx_last); end
      vectors++; if (bm.tx_byte !== 8'h00) begin miscompares++; $display("FAIL rst_byte: got %h want 00", bm.tx_byte); end
      vectors++; if (busy_m !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy_m); end
      vectors++; if (cnt_m !== 16'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", cnt_m); end
      rst = 1'b0;
   endtask

   task automatic test_basic_msb();
      clear_sb();
      run_cycles(1);
      present_block(64'h0123456789ABCDEF);
      run_cycles(3);
      vectors++; if (busy_m !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b want 1", busy_m); end
      run_cycles(10);
      vectors++; if (ack_cnt !== 1) begin miscompares++; $display("FAIL basic_acks: got %0d want 1", ack_cnt); end
      vectors++; if (vld_cnt !== 8 || last_vld - first_vld !== 7) begin miscompares++; $display("FAIL basic_valid_run: got %0d cycles span %0d want 8 span 7", vld_cnt, last_vld - first_vld); end
      vectors++; if (last_ack !== first_vld) begin miscompares++; $display("FAIL basic_ack_timing: got ack cycle %0d want %0d", last_ack, first_vld); end
      while (exp_m.size() > 0) begin
         logic [8:0] e, o;
         e = exp_m.pop_front(); o = (obs_m.size() > 0) ? obs_m.pop_front() : 9'h1xx;
         vectors++; if (o !== e) begin miscompares++; $display("FAIL basic_byte: got %h want %h", o, e); end
      end
      vectors++; if (obs_m.size() !== 0) begin miscompares++; $display("FAIL basic_extra: got %0d extra bytes want 0", obs_m.size()); end
      vectors++; if (cnt_m !== 16'(exp_blocks)) begin miscompares++; $display("FAIL basic_count: got %0d want %0d", cnt_m, exp_blocks); end
      vectors++; if (busy_m !== 1'b0) begin miscompares++; $display("FAIL basic_idle_busy: got %b want 0", busy_m); end
   endtask

   task automatic test_lsb_first();
      clear_sb();
      present_block(64'h0123456789ABCDEF);
      run_cycles(12);
      while (exp_l.size() > 0) begin
         logic [8:0] e, o;
         e = exp_l.pop_front(); o = (obs_l.size() > 0) ? obs_l.pop_front() : 9'h1xx;
         vectors++; if (o !== e) begin miscompares++; $display("FAIL lsb_byte: got %h want %h", o, e); end
      end
      vectors++; if (obs_l.size() !== 0) begin miscompares++; $display("FAIL lsb_extra: got %0d extra bytes want 0", obs_l.size()); end
      vectors++; if (cnt_l !== 16'(exp_blocks)) begin miscompares++; $display("FAIL lsb_count: got %0d want %0d", cnt_l, exp_blocks); end
   endtask

   task automatic test_backpressure();
      clear_sb();
      present_block(64'h0123456789ABCDEF);
      run_cycles(4);
      txr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++; if (bm.tx_byte !== 8'h67 || bm.tx_valid !== 1'b1 || bm.tx_last !== 1'b0) begin
            miscompares++; $display("FAIL bp_stall: got byte %h valid %b last %b want 67 1 0", bm.tx_byte, bm.tx_valid, bm.tx_last);
         end
         tick();
      end
      txr = 1'b1;
      run_cycles(10);
      while (exp_m.size() > 0) begin
         logic [8:0] e, o;
         e = exp_m.pop_front(); o = (obs_m.size() > 0) ? obs_m.pop_front() : 9'h1xx;
         vectors++; if (o !== e) begin miscompares++; $display("FAIL bp_byte: got %h want %h", o, e); end
      end
      vectors++; if (cnt_m !== 16'(exp_blocks)) begin miscompares++; $display("FAIL bp_count: got %0d want %0d", cnt_m, exp_blocks); end
   endtask

   task automatic test_no_double_capture();
      clear_sb();
      hold_high = 1'b1;
      present_block(64'hA5A5_5A5A_F00D_BEEF);
      run_cycles(20);
      vectors++; if (ack_cnt !== 1) begin miscompares++; $display("FAIL nodbl_acks: got %0d want 1", ack_cnt); end
      vectors++; if (vld_cnt !== 8) begin miscompares++; $display("FAIL nodbl_valid: got %0d want 8", vld_cnt); end
      vectors++; if (cnt_m !== 16'(exp_blocks)) begin miscompares++; $display("FAIL nodbl_count: got %0d want %0d", cnt_m, exp_blocks); end
      hold_high = 1'b0; tdr = 1'b0;
      run_cycles(2);
      vectors++; if (bm.tx_valid !== 1'b0) begin miscompares++; $display("FAIL nodbl_rearm_valid: got %b want 0", bm.tx_valid); end
      present_block(64'h1122334455667788);
      run_cycles(12);
      vectors++; if (ack_cnt !== 2) begin miscompares++; $display("FAIL nodbl_rearm_acks: got %0d want 2", ack_cnt); end
      while (exp_m.size() > 0) begin
         logic [8:0] e, o;
         e = exp_m.pop_front(); o = (obs_m.size() > 0) ? obs_m.pop_front() : 9'h1xx;
         vectors++; if (o !== e) begin miscompares++; $display("FAIL nodbl_byte: got %h want %h", o, e); end
      end
      vectors++; if (cnt_m !== 16'(exp_blocks)) begin miscompares++; $display("FAIL nodbl_rearm_count: got %0d want %0d", cnt_m, exp_blocks); end
   endtask

   task automatic test_back_to_back();
      clear_sb();
      present_block(64'hDEADBEEFCAFEF00D);
      run_cycles(2);
      present_block(64'h0F1E2D3C4B5A6978);
      run_cycles(25);
      vectors++; if (ack_cnt !== 2) begin miscompares++; $display("FAIL b2b_acks: got %0d want 2", ack_cnt); end
      vectors++; if (vld_cnt !== 16) begin miscompares++; $display("FAIL b2b_valid: got %0d want 16", vld_cnt); end
`ifdef DES_SER_DOUBLE_BUF_EN
      vectors++; if (last_vld - first_vld !== 15) begin miscompares++; $display("FAIL b2b_span: got %0d want 15", last_vld - first_vld); end
      vectors++; if (last_ack - first_vld !== 2) begin miscompares++; $display("FAIL b2b_ack_cycle: got %0d want 2", last_ack - first_vld); end
`else
      vectors++; if (last_vld - first_vld !== 16) begin miscompares++; $display("FAIL b2b_span: got %0d want 16", last_vld - first_vld); end
      vectors++; if (last_ack - first_vld !== 9) begin miscompares++; $display("FAIL b2b_ack_cycle: got %0d want 9", last_ack - first_vld); end
`endif
      while (exp_m.size() > 0) begin
         logic [8:0] e, o;
         e = exp_m.pop_front(); o = (obs_m.size() > 0) ? obs_m.pop_front() : 9'h1xx;
         vectors++; if (o !== e) begin miscompares++; $display("FAIL b2b_byte: got %h want %h", o, e); end
      end
      vectors++; if (cnt_m !== 16'(exp_blocks)) begin miscompares++; $display("FAIL b2b_count: got %0d want %0d", cnt_m, exp_blocks); end
   endtask

   task automatic test_reset_mid_block();
      clear_sb();
      present_block(64'hFEDCBA9876543210);
      run_cycles(6);
      while (obs_m.size() > 0) begin
         logic [8:0] e, o;
         e = exp_m.pop_front(); o = obs_m.pop_front();
         vectors++; if (o !== e) begin miscompares++; $display("FAIL rstmid_byte: got %h want %h", o, e); end
      end
      rst = 1'b1;
      tick();
      vectors++; if (bm.tx_valid !== 1'b0 || busy_m !== 1'b0 || cnt_m !== 16'd0 || bm.handshake_ack !== 1'b0) begin
         miscompares++; $display("FAIL rstmid_state: got valid %b busy %b count %0d ack %b want 0 0 0 0", bm.tx_valid, busy_m, cnt_m, bm.handshake_ack);
      end
      rst = 1'b0; exp_blocks = 0;
      clear_sb();
      run_cycles(6);
      vectors++; if (ack_cnt !== 0 || vld_cnt !== 0) begin miscompares++; $display("FAIL rstmid_quiet: got acks %0d valid %0d want 0 0", ack_cnt, vld_cnt); end
   endtask

   task automatic test_wrap();
      clear_sb();
      for (int b = 0; b < 9; b++) begin
         present_block({$urandom, $urandom});
         run_cycles(11);
         vectors++; if (cnt_w !== 3'(exp_blocks % 8)) begin miscompares++; $display("FAIL wrap_count3: got %0d want %0d", cnt_w, exp_blocks % 8); end
         vectors++; if (cnt_m !== 16'(exp_blocks)) begin miscompares++; $display("FAIL wrap_count16: got %0d want %0d", cnt_m, exp_blocks); end
      end
      vectors++; if (ack_cnt !== 9) begin miscompares++; $display("FAIL wrap_acks: got %0d want 9", ack_cnt); end
      while (exp_m.size() > 0) begin
         logic [8:0] e, o;
         e = exp_m.pop_front(); o = (obs_m.size() > 0) ? obs_m.pop_front() : 9'h1xx;
         vectors++; if (o !== e) begin miscompares++; $display("FAIL wrap_byte: got %h want %h", o, e); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_msb();
      test_lsb_first();
      test_backpressure();
      test_no_double_capture();
      test_back_to_back();
      test_reset_mid_block();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
